// File: rtl/fft384_pkg.sv
// Shared constants and FSM encoding for the 384-carrier FFT twiddle sequencer.
package fft384_pkg;

    localparam int N_CAR = 384;
    localparam int CW    = 9;
    localparam int SW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lat_align.sv
// One register stage that lines the last-carrier/last-symbol flags up with
// the twiddle ROM output, which lags its din_vld by one cycle.
module lat_align (
    input  logic clk,
    input  logic n_rst,
    input  logic i_last_car,
    input  logic i_last_sym,
    output logic o_tag_last_car,
    output logic o_tag_last_sym
);

    logic r_tag_last_car;
    logic r_tag_last_sym;

    // Flag delay register matching ROM read latency.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tag_last_car <= 1'b0;
            r_tag_last_sym <= 1'b0;
        end else begin
            r_tag_last_car <= i_last_car;
            r_tag_last_sym <= i_last_sym;
        end
    end

    assign o_tag_last_car = r_tag_last_car;
    assign o_tag_last_sym = r_tag_last_sym;

endmodule

// File: rtl/twiddle_seq_384.sv
// Twiddle ROM address sequencer: walks carriers 0..N_CAR-1 for n_sym symbols
// per burst, honouring stall/abort, and tags the last carrier/symbol.
module twiddle_seq_384 #(
    parameter int N_CAR = fft384_pkg::N_CAR,
    parameter int CW    = fft384_pkg::CW,
    parameter int SW    = fft384_pkg::SW
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [SW-1:0] n_sym,
    input  logic          stall,
    input  logic          abort,
    output logic [CW-1:0] rom_num,
    output logic          rom_vld,
    output logic          tag_last_car,
    output logic          tag_last_sym,
    output logic [SW-1:0] sym_idx,
    output logic          busy,
    output logic          done
);

    import fft384_pkg::*;

    state_e        r_state,     w_state_nxt;
    logic [CW-1:0] r_car,       w_car_nxt;
    logic [SW-1:0] r_sym_cnt,   w_sym_cnt_nxt;
    logic [SW-1:0] r_nsym,      w_nsym_nxt;
    logic [CW-1:0] r_rom_num,   w_rom_num_nxt;
    logic [SW-1:0] r_sym_idx,   w_sym_idx_nxt;
    logic          r_rom_vld,   w_rom_vld_nxt;
    logic          r_last_car,  w_last_car_nxt;
    logic          r_last_sym,  w_last_sym_nxt;
    logic          r_busy,      w_busy_nxt;
    logic          r_done,      w_done_nxt;
    logic          w_car_last;
    logic          w_sym_last;

    assign w_car_last = (r_car == CW'(N_CAR - 1));
    assign w_sym_last = (r_sym_cnt == (r_nsym - SW'(1)));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_car_nxt      = r_car;
        w_sym_cnt_nxt  = r_sym_cnt;
        w_nsym_nxt     = r_nsym;
        w_rom_num_nxt  = r_rom_num;
        w_sym_idx_nxt  = r_sym_idx;
        w_rom_vld_nxt  = 1'b0;
        w_last_car_nxt = 1'b0;
        w_last_sym_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (n_sym != SW'(0))) begin
                    w_nsym_nxt    = n_sym;
                    w_car_nxt     = CW'(0);
                    w_sym_cnt_nxt = SW'(0);
                    w_sym_idx_nxt = SW'(0);
                    w_state_nxt   = ST_RUN;
                end else if (start) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (stall) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_rom_vld_nxt  = 1'b1;
                    w_rom_num_nxt  = r_car;
                    w_sym_idx_nxt  = r_sym_cnt;
                    w_last_car_nxt = w_car_last;
                    w_last_sym_nxt = w_car_last && w_sym_last;
                    if (w_car_last) begin
                        w_car_nxt     = CW'(0);
                        w_sym_cnt_nxt = r_sym_cnt + SW'(1);
                        w_state_nxt   = w_sym_last ? ST_DONE : ST_RUN;
                    end else begin
                        w_car_nxt = r_car + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_RUN);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_car      <= CW'(0);
            r_sym_cnt  <= SW'(0);
            r_nsym     <= SW'(0);
            r_rom_num  <= CW'(0);
            r_sym_idx  <= SW'(0);
            r_rom_vld  <= 1'b0;
            r_last_car <= 1'b0;
            r_last_sym <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_car      <= w_car_nxt;
            r_sym_cnt  <= w_sym_cnt_nxt;
            r_nsym     <= w_nsym_nxt;
            r_rom_num  <= w_rom_num_nxt;
            r_sym_idx  <= w_sym_idx_nxt;
            r_rom_vld  <= w_rom_vld_nxt;
            r_last_car <= w_last_car_nxt;
            r_last_sym <= w_last_sym_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    lat_align u_lat_align (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_last_car     (r_last_car),
        .i_last_sym     (r_last_sym),
        .o_tag_last_car (tag_last_car),
        .o_tag_last_sym (tag_last_sym)
    );

    assign rom_num = r_rom_num;
    assign rom_vld = r_rom_vld;
    assign sym_idx = r_sym_idx;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_twiddle_seq_384.sv
// Randomized self-checking bench for twiddle_seq_384 against a queue-based
// model of the expected (symbol, carrier) issue order.
module tb_twiddle_seq_384;

    import fft384_pkg::*;

    localparam int NC = fft384_pkg::N_CAR;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [SW-1:0] n_sym;
    logic          stall;
    logic          abort;
    logic [CW-1:0] rom_num;
    logic          rom_vld;
    logic          tag_last_car;
    logic          tag_last_sym;
    logic [SW-1:0] sym_idx;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    twiddle_seq_384 dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .n_sym        (n_sym),
        .stall        (stall),
        .abort        (abort),
        .rom_num      (rom_num),
        .rom_vld      (rom_vld),
        .tag_last_car (tag_last_car),
        .tag_last_sym (tag_last_sym),
        .sym_idx      (sym_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_num"}, 32'(rom_num), 32'd0);
        chk({tag, "_rom_vld"}, 32'(rom_vld), 32'd0);
        chk({tag, "_tag_car"}, 32'(tag_last_car), 32'd0);
        chk({tag, "_tag_sym"}, 32'(tag_last_sym), 32'd0);
        chk({tag, "_sym_idx"}, 32'(sym_idx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // mode: 0 no stall, 1 random stall, 2 stall the final issue for 3 cycles.
    // abort_sym < 0 disables abort; otherwise abort once (abort_sym, abort_car) is seen.
    task automatic run_burst(input int ns, input int mode, input int abort_sym, input int abort_car);
        int  q_s[$];
        int  q_c[$];
        int  last_num;
        int  budget;
        int  fin_stall;
        int  pc;
        bit  issued_any;
        bit  running;
        bit  was_running;
        bit  exp_tag_car;
        bit  exp_tag_sym;
        bit  exp_done;
        bit  finished;
        bit  abort_pend;
        bit  st;
        for (int s = 0; s < ns; s++)
            for (int c = 0; c < NC; c++) begin
                q_s.push_back(s);
                q_c.push_back(c);
            end
        last_num    = 0;
        issued_any  = 1'b0;
        fin_stall   = 0;
        exp_tag_car = 1'b0;
        exp_tag_sym = 1'b0;
        exp_done    = (ns == 0);
        finished    = 1'b0;
        abort_pend  = 1'b0;
        budget      = ns * NC * 4 + 20;

        n_sym = SW'(ns);
        start = 1'b1;
        stall = 1'b0;
        abort = 1'b0;
        tick();
        start = 1'b0;
        running = (ns != 0);
        chk("accept_busy", 32'(busy), 32'(running));
        chk("accept_rom_vld", 32'(rom_vld), 32'd0);

        while (!finished && budget > 0) begin
            budget--;
            case (mode)
                1: st = ($urandom_range(0, 3) == 0);
                2: begin
                    st = (q_s.size() == 1) && (fin_stall < 3);
                    if (st) fin_stall++;
                end
                default: st = 1'b0;
            endcase
            stall = st;
            abort = abort_pend;
            if (abort_pend) stall = 1'b1;
            tick();
            was_running = running;

            if (abort_pend) begin
                chk("abort_rom_vld", 32'(rom_vld), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                abort = 1'b0;
                stall = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    chk("post_abort_vld", 32'(rom_vld), 32'd0);
                    chk("post_abort_done", 32'(done), 32'd0);
                    chk("post_abort_busy", 32'(busy), 32'd0);
                end
                return;
            end

            chk("rom_vld", 32'(rom_vld), 32'(was_running && !st));
            chk("tag_last_car", 32'(tag_last_car), 32'(exp_tag_car));
            chk("tag_last_sym", 32'(tag_last_sym), 32'(exp_tag_sym));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) finished = 1'b1;

            exp_tag_car = 1'b0;
            exp_tag_sym = 1'b0;
            exp_done    = 1'b0;
            if (rom_vld && q_s.size() > 0) begin
                chk("rom_num", 32'(rom_num), 32'(q_c[0]));
                chk("sym_idx", 32'(sym_idx), 32'(q_s[0]));
                pc = q_c.pop_front();
                void'(q_s.pop_front());
                last_num    = pc;
                issued_any  = 1'b1;
                exp_tag_car = (pc == NC - 1);
                exp_tag_sym = (q_s.size() == 0);
                exp_done    = (q_s.size() == 0);
                if (abort_sym >= 0 && int'(sym_idx) == abort_sym && pc == abort_car)
                    abort_pend = 1'b1;
            end else if (was_running && issued_any) begin
                chk("stall_hold", 32'(rom_num), 32'(last_num));
            end
            running = (q_s.size() != 0);
            chk("busy", 32'(busy), 32'(running));
        end
        if (!finished) chk("timeout", 32'd0, 32'd1);
        tick();
        chk("end_done", 32'(done), 32'd0);
        chk("end_rom_vld", 32'(rom_vld), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_tag_car", 32'(tag_last_car), 32'd0);
        chk("end_queue", 32'(q_s.size()), 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        n_sym = SW'(0);
        stall = 1'b0;
        abort = 1'b0;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        chk_all_zero("idle");

        run_burst(1, 0, -1, 0);
        run_burst(3, 1, -1, 0);
        run_burst(0, 0, -1, 0);
        run_burst(2, 0, 1, 100);
        run_burst(1, 1, -1, 0);

        // Asynchronous reset mid-burst, checked before any further clock edge.
        n_sym = SW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #1;
        n_rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #10;
        n_rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst_wait_vld", 32'(rom_vld), 32'd0);
            chk("rst_wait_busy", 32'(busy), 32'd0);
        end

        run_burst(1, 1, -1, 0);
        run_burst(1, 2, -1, 0);
        run_burst(2, 1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
